// File: rtl/step_ramp_ctrl.sv
// step_ramp_ctrl: trapezoidal step-pulse sequencer for one stepper axis.
// A move command launches a train of one-cycle step pulses. The gap between
// pulses is set by a period counter (counts 0..P-1, fires on terminal count);
// P is reloaded after each step so the axis ramps up, cruises and ramps down
// symmetrically. An abort turns the move into a controlled decelerating stop.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   start_in        move request, sampled only when idle
//   steps_in        number of steps to emit
//   dir_in          direction, latched at start
//   period_start_in start/stop period P0 (cycles, 0 treated as 1)
//   period_min_in   cruise period Pmin (cycles, 0 treated as 1, clamped to P0)
//   accel_in        period change per step during ramps
//   abort_in        request a controlled decelerating stop
//   step_out        step pulse, one cycle per step
//   dir_out         latched direction, held until the next start
//   busy_out        move in progress
//   done_out        one-cycle pulse at the end of a move
//   period_out      period currently loaded, held after done
module step_ramp_ctrl #(
  parameter int SIZE    = 16,
  parameter int STEPS_W = 24
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [STEPS_W-1:0] steps_in,
  input  logic               dir_in,
  input  logic [SIZE-1:0]    period_start_in,
  input  logic [SIZE-1:0]    period_min_in,
  input  logic [SIZE-1:0]    accel_in,
  input  logic               abort_in,
  output logic               step_out,
  output logic               dir_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [SIZE-1:0]    period_out
);

  localparam logic [SIZE-1:0]    P_ZERO = {SIZE{1'b0}};
  localparam logic [SIZE-1:0]    P_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [STEPS_W-1:0] S_ZERO = {STEPS_W{1'b0}};
  localparam logic [STEPS_W-1:0] S_ONE  = {{(STEPS_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

  state_t             state_r;
  logic [SIZE-1:0]    cnt_r;
  logic [SIZE-1:0]    period_r;
  logic [SIZE-1:0]    p0_r;
  logic [SIZE-1:0]    pmin_r;
  logic [SIZE-1:0]    accel_r;
  logic [STEPS_W-1:0] steps_left_r;
  logic [STEPS_W-1:0] ramp_cnt_r;
  logic               abort_r;
  logic               fin_r;       // last step emitted, done pulse due next edge
  logic               step_r;
  logic               done_r;
  logic               busy_r;
  logic               dir_r;

  logic [SIZE-1:0]    p0_eff_s;
  logic [SIZE-1:0]    pmin_raw_s;
  logic [SIZE-1:0]    pmin_eff_s;
  logic [SIZE-1:0]    period_up_s;
  logic [SIZE-1:0]    period_dn_s;
  logic [STEPS_W-1:0] rem_s;
  logic [STEPS_W-1:0] ramp_step_s;
  logic [STEPS_W-1:0] sl_step_s;
  logic [STEPS_W-1:0] sl_clamp_s;
  logic               term_s;
  logic               decel_s;

  // Normalise the start-time period inputs: zero means one, Pmin never above P0
  always_comb begin
    p0_eff_s   = (period_start_in == P_ZERO) ? P_ONE : period_start_in;
    pmin_raw_s = (period_min_in == P_ZERO) ? P_ONE : period_min_in;
    pmin_eff_s = (pmin_raw_s > p0_eff_s) ? p0_eff_s : pmin_raw_s;
  end

  // Terminal count detection and per-step ramp arithmetic
  always_comb begin
    term_s  = busy_r && !fin_r && (cnt_r == (period_r - P_ONE));
    rem_s   = steps_left_r - S_ONE;
    decel_s = (rem_s <= ramp_cnt_r) || abort_r;
    // Saturating ramps: compare the headroom first so the result never wraps.
    period_up_s = ((p0_r - period_r) > accel_r) ? (period_r + accel_r) : p0_r;
    period_dn_s = ((period_r - pmin_r) > accel_r) ? (period_r - accel_r) : pmin_r;
    ramp_step_s = ramp_cnt_r;
    if (term_s && (rem_s != S_ZERO)) begin
      if (decel_s) begin
        ramp_step_s = (ramp_cnt_r == S_ZERO) ? S_ZERO : (ramp_cnt_r - S_ONE);
      end else if (state_r == ST_ACCEL) begin
        ramp_step_s = ramp_cnt_r + S_ONE;
      end else begin
        ramp_step_s = ramp_cnt_r;
      end
    end else begin
      ramp_step_s = ramp_cnt_r;
    end
    // An abort clamps the post-step count so that exactly ramp_cnt
    // decelerating steps follow the pending one.
    sl_step_s  = term_s ? rem_s : steps_left_r;
    sl_clamp_s = (sl_step_s > ramp_step_s) ? (ramp_step_s + S_ONE) : sl_step_s;
  end

  // Sequencer FSM: start handshake, period counter, ramp profile and outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      cnt_r        <= P_ZERO;
      period_r     <= P_ZERO;
      p0_r         <= P_ZERO;
      pmin_r       <= P_ZERO;
      accel_r      <= P_ZERO;
      steps_left_r <= S_ZERO;
      ramp_cnt_r   <= S_ZERO;
      abort_r      <= 1'b0;
      fin_r        <= 1'b0;
      step_r       <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      dir_r        <= 1'b0;
    end else begin
      step_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_in && (steps_in == S_ZERO)) begin
            done_r <= 1'b1;
          end else if (start_in) begin
            dir_r        <= dir_in;
            steps_left_r <= steps_in;
            p0_r         <= p0_eff_s;
            pmin_r       <= pmin_eff_s;
            accel_r      <= accel_in;
            period_r     <= p0_eff_s;
            cnt_r        <= P_ZERO;
            ramp_cnt_r   <= S_ZERO;
            abort_r      <= 1'b0;
            fin_r        <= 1'b0;
            busy_r       <= 1'b1;
            if ((pmin_eff_s == p0_eff_s) || (accel_in == P_ZERO)) begin
              state_r <= ST_CRUISE;
            end else begin
              state_r <= ST_ACCEL;
            end
          end
        end
        ST_ACCEL, ST_CRUISE, ST_DECEL: begin
          if (fin_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            fin_r   <= 1'b0;
            abort_r <= 1'b0;
            cnt_r   <= P_ZERO;
          end else begin
            cnt_r        <= term_s ? P_ZERO : (cnt_r + P_ONE);
            steps_left_r <= abort_in ? sl_clamp_s : sl_step_s;
            ramp_cnt_r   <= ramp_step_s;
            if (abort_in) begin
              abort_r <= 1'b1;
            end
            if (term_s) begin
              step_r <= 1'b1;
              if (rem_s == S_ZERO) begin
                fin_r <= 1'b1;
              end else if (decel_s) begin
                state_r  <= ST_DECEL;
                period_r <= period_up_s;
              end else if (state_r == ST_ACCEL) begin
                period_r <= period_dn_s;
                if (period_dn_s == pmin_r) begin
                  state_r <= ST_CRUISE;
                end
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign step_out   = step_r;
  assign dir_out    = dir_r;
  assign busy_out   = busy_r;
  assign done_out   = done_r;
  assign period_out = period_r;

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Self-checking bench for step_ramp_ctrl: directed profiles with hand-derived
// step times plus randomized moves checked against a per-step reference model.
module tb_step_ramp_ctrl;
  localparam int SIZE    = 16;
  localparam int STEPS_W = 24;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               start_in = 1'b0;
  logic [STEPS_W-1:0] steps_in = '0;
  logic               dir_in = 1'b0;
  logic [SIZE-1:0]    period_start_in = '0;
  logic [SIZE-1:0]    period_min_in = '0;
  logic [SIZE-1:0]    accel_in = '0;
  logic               abort_in = 1'b0;
  logic               step_out;
  logic               dir_out;
  logic               busy_out;
  logic               done_out;
  logic [SIZE-1:0]    period_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  // observations of one move (cycle index n = samples after start edge k+n)
  int obs_q[$];
  int obs_done, obs_done_cnt, obs_busy, obs_period, obs_dir;
  // reference expectations
  int exp_q[$];
  int exp_done, exp_period;

  step_ramp_ctrl #(.SIZE(SIZE), .STEPS_W(STEPS_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .steps_in(steps_in),
    .dir_in(dir_in), .period_start_in(period_start_in), .period_min_in(period_min_in),
    .accel_in(accel_in), .abort_in(abort_in), .step_out(step_out), .dir_out(dir_out),
    .busy_out(busy_out), .done_out(done_out), .period_out(period_out)
  );

  always #5 clk_in = ~clk_in;

  // Launch a move and record what the DUT does; inputs are scrambled during
  // the move, abort pulses at edge k+abort_at, start re-pulses at k+restart_at+1.
  task automatic run_move(input int p0, input int pmin, input int acc, input int steps,
                          input bit dir, input int abort_at, input int restart_at);
    obs_q.delete();
    obs_done = -1; obs_done_cnt = 0; obs_busy = 0; obs_period = -1; obs_dir = -1;
    period_start_in = SIZE'(p0);
    period_min_in   = SIZE'(pmin);
    accel_in        = SIZE'(acc);
    steps_in        = STEPS_W'(steps);
    dir_in          = dir;
    start_in        = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin @(posedge clk_in); #1; end
      if (step_out) obs_q.push_back(n);
      if (busy_out) obs_busy++;
      if (done_out) begin
        obs_done_cnt++;
        if (obs_done < 0) begin
          obs_done = n; obs_period = int'(period_out); obs_dir = int'(dir_out);
        end
      end
      if (obs_done >= 0 && n >= obs_done + 3) break;
      abort_in        = (n == abort_at - 1);
      start_in        = (n == restart_at);
      steps_in        = STEPS_W'($urandom_range(1, 5));
      period_start_in = SIZE'($urandom_range(1, 3));
      period_min_in   = SIZE'(1);
      accel_in        = SIZE'($urandom_range(0, 3));
      dir_in          = 1'($urandom_range(0, 1));
    end
    abort_in = 1'b0;
    start_in = 1'b0;
  endtask

  // Reference: walk the move one step at a time using the ramp rules.
  task automatic model_move(input int p0, input int pmin, input int acc, input int steps,
                            input int abort_at);
    int p0e, pme, period, ramp, left, t, tstep;
    bit accelerating, aborted;
    exp_q.delete();
    p0e = (p0 == 0) ? 1 : p0;
    pme = (pmin == 0) ? 1 : pmin;
    if (pme > p0e) pme = p0e;
    accelerating = !(pme == p0e || acc == 0);
    period = p0e; ramp = 0; left = steps; t = 0; aborted = 0;
    exp_done = 0; exp_period = p0e;
    while (left > 0) begin
      tstep = t + period;
      if (!aborted && abort_at > t && abort_at < tstep) begin
        if (left > ramp + 1) left = ramp + 1;
        aborted = 1;
      end
      left--;
      exp_q.push_back(tstep);
      if (left > 0) begin
        if (left <= ramp || aborted) begin
          period = (period + acc > p0e) ? p0e : period + acc;
          ramp = (ramp > 0) ? ramp - 1 : 0;
          accelerating = 0;
        end else if (accelerating) begin
          period = (period - acc < pme) ? pme : period - acc;
          ramp++;
          if (period == pme) accelerating = 0;
        end
        if (!aborted && abort_at == tstep) begin
          if (left > ramp + 1) left = ramp + 1;
          aborted = 1;
        end
      end
      t = tstep;
      exp_done = t + 1;
      exp_period = period;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_in = 1'b1;
    start_in = 1'b1; steps_in = STEPS_W'(5); period_start_in = SIZE'(2);
    period_min_in = SIZE'(1); accel_in = SIZE'(1); dir_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    total_cnt++; if (step_out !== 1'b0) $display("FAIL rst_step: got %b want 0", step_out); else pass_cnt++;
    total_cnt++; if (dir_out !== 1'b0) $display("FAIL rst_dir: got %b want 0", dir_out); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else pass_cnt++;
    total_cnt++; if (done_out !== 1'b0) $display("FAIL rst_done: got %b want 0", done_out); else pass_cnt++;
    total_cnt++; if (period_out !== 16'd0) $display("FAIL rst_period: got %0d want 0", period_out); else pass_cnt++;
    start_in = 1'b0;
    rst_in = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (step_out !== 1'b0 || dir_out !== 1'b0 || busy_out !== 1'b0 ||
          done_out !== 1'b0 || period_out !== 16'd0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL rst_idle20: %0d nonzero samples, want 0", bad); else pass_cnt++;
  endtask

  task automatic test_profiles();
    int p0, pm, ac, st, ab, rs;
    string nm;
    for (int r = 0; r < 7; r++) begin
      rs = -1; ab = 0;
      case (r)
        0: begin p0 = 10; pm = 4;  ac = 2; st = 8;  exp_q = {10, 18, 24, 28, 32, 38, 46, 56}; exp_done = 57; exp_period = 10; end
        1: begin p0 = 10; pm = 4;  ac = 2; st = 3;  exp_q = {10, 18, 28}; exp_done = 29; exp_period = 10; end
        2: begin p0 = 10; pm = 4;  ac = 2; st = 20; ab = 34;
                 exp_q = {10, 18, 24, 28, 32, 36, 42, 50, 60}; exp_done = 61; exp_period = 10; end
        3: begin p0 = 10; pm = 12; ac = 2; st = 4;  exp_q = {10, 20, 30, 40}; exp_done = 41; exp_period = 10; end
        4: begin p0 = 0;  pm = 0;  ac = 2; st = 3;  exp_q = {1, 2, 3}; exp_done = 4; exp_period = 1; end
        5: begin p0 = 8;  pm = 4;  ac = 7; st = 4;  exp_q = {8, 12, 16, 24}; exp_done = 25; exp_period = 8; end
        default: begin p0 = 10; pm = 4; ac = 2; st = 8; rs = 5;
                 exp_q = {10, 18, 24, 28, 32, 38, 46, 56}; exp_done = 57; exp_period = 10; end
      endcase
      nm = $sformatf("prof%0d", r);
      run_move(p0, pm, ac, st, r[0], ab, rs);
      total_cnt++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL %s_nsteps: got %0d want %0d", nm, obs_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL %s_step%0d: at k+%0d want k+%0d", nm, i, obs_q[i], exp_q[i]);
        else pass_cnt++;
      end
      total_cnt++; if (obs_done !== exp_done) $display("FAIL %s_done: at k+%0d want k+%0d", nm, obs_done, exp_done); else pass_cnt++;
      total_cnt++; if (obs_done_cnt !== 1) $display("FAIL %s_donecnt: got %0d want 1", nm, obs_done_cnt); else pass_cnt++;
      total_cnt++; if (obs_busy !== exp_done) $display("FAIL %s_busy: %0d cycles want %0d", nm, obs_busy, exp_done); else pass_cnt++;
      total_cnt++; if (obs_period !== exp_period) $display("FAIL %s_period: got %0d want %0d", nm, obs_period, exp_period); else pass_cnt++;
      total_cnt++; if (obs_dir !== int'(r[0])) $display("FAIL %s_dir: got %0d want %0d", nm, obs_dir, r[0]); else pass_cnt++;
    end
  endtask

  task automatic test_zero_steps();
    run_move(5, 2, 1, 0, 1'b1, 0, -1);
    total_cnt++; if (obs_done !== 0) $display("FAIL zero_done: at k+%0d want k+0", obs_done); else pass_cnt++;
    total_cnt++; if (obs_done_cnt !== 1) $display("FAIL zero_donecnt: got %0d want 1", obs_done_cnt); else pass_cnt++;
    total_cnt++; if (obs_busy !== 0) $display("FAIL zero_busy: %0d cycles want 0", obs_busy); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== 0) $display("FAIL zero_steps: %0d steps want 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad;
    period_start_in = SIZE'(10); period_min_in = SIZE'(4); accel_in = SIZE'(2);
    steps_in = STEPS_W'(20); dir_in = 1'b1; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (30) begin @(posedge clk_in); #1; end
    total_cnt++; if (busy_out !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy_out); else pass_cnt++;
    total_cnt++; if (period_out !== 16'd4) $display("FAIL mid_period: got %0d want 4", period_out); else pass_cnt++;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    total_cnt++;
    if (step_out !== 1'b0 || dir_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 || period_out !== 16'd0)
      $display("FAIL mid_rst: step=%b dir=%b busy=%b done=%b period=%0d want all 0",
               step_out, dir_out, busy_out, done_out, period_out);
    else pass_cnt++;
    bad = 0;
    repeat (15) begin
      @(posedge clk_in); #1;
      if (step_out !== 1'b0 || done_out !== 1'b0 || busy_out !== 1'b0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL mid_after: %0d active samples, want 0", bad); else pass_cnt++;
  endtask

  task automatic test_random();
    int p0, pm, ac, st, ab;
    bit dr;
    for (int it = 0; it < 30; it++) begin
      p0 = $urandom_range(0, 12);
      pm = $urandom_range(0, 14);
      ac = $urandom_range(0, 5);
      st = $urandom_range(0, 14);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 100) : 0;
      dr = 1'($urandom_range(0, 1));
      model_move(p0, pm, ac, st, ab);
      run_move(p0, pm, ac, st, dr, ab, -1);
      total_cnt++;
      if (obs_q.size() !== exp_q.size())
        $display("FAIL rnd%0d_nsteps: got %0d want %0d (p0=%0d pmin=%0d acc=%0d steps=%0d abort=%0d)",
                 it, obs_q.size(), exp_q.size(), p0, pm, ac, st, ab);
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rnd%0d_step%0d: at k+%0d want k+%0d", it, i, obs_q[i], exp_q[i]);
        else pass_cnt++;
      end
      total_cnt++; if (obs_done !== exp_done) $display("FAIL rnd%0d_done: at k+%0d want k+%0d", it, obs_done, exp_done); else pass_cnt++;
      total_cnt++; if (obs_busy !== exp_done) $display("FAIL rnd%0d_busy: %0d cycles want %0d", it, obs_busy, exp_done); else pass_cnt++;
      if (st > 0) begin
        total_cnt++; if (obs_period !== exp_period) $display("FAIL rnd%0d_period: got %0d want %0d", it, obs_period, exp_period); else pass_cnt++;
        total_cnt++; if (obs_dir !== int'(dr)) $display("FAIL rnd%0d_dir: got %0d want %0d", it, obs_dir, dr); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_profiles();
    test_zero_steps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/step_ramp_ctrl.md
Name: step_ramp_ctrl

Overview:
Trapezoidal step-pulse sequencer for one stepper axis. It accepts a move command and emits one-cycle step pulses. The spacing between pulses comes from an internal period counter that works like the divider: it counts 0..P-1 and pulses on the terminal count. P is reloaded after every step, so the axis accelerates, cruises and decelerates symmetrically. It sits between the motion command logic and the step/dir driver pins.

Parameters:
SIZE, 16, width of period values and the period counter (clock cycles)
STEPS_W, 24, width of the step-count command and the internal step/ramp counters

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset (one clock; reset is synchronous and active-high)
start_in  input  1  move request; sampled only when idle
steps_in  input  STEPS_W  number of steps to emit
dir_in  input  1  direction, latched at start
period_start_in  input  SIZE  start/stop period P0 in cycles
period_min_in  input  SIZE  cruise period Pmin in cycles
accel_in  input  SIZE  period change per step during ramps
abort_in  input  1  request a controlled decelerating stop
step_out  output  1  step pulse, high exactly one cycle per step
dir_out  output  1  latched direction
busy_out  output  1  move in progress
done_out  output  1  one-cycle pulse at end of move
period_out  output  SIZE  period currently loaded

Behaviour:
- Reset (synchronous, any state): state=IDLE; all counters 0; step_out=0, dir_out=0, busy_out=0, done_out=0, period_out=0. Reset mid-move kills the move immediately; no done pulse is emitted.
- States: IDLE, ACCEL, CRUISE, DECEL.
- Start handshake, IDLE with start_in=1 at edge k:
  - Latch dir, steps_left=steps_in, P0 and Pmin.
  - Period 0 is treated as 1. If Pmin>P0, then Pmin:=P0.
  - Load period=P0, cnt=0, ramp_cnt=0.
  - busy_out=1 after edge k. State becomes ACCEL, or CRUISE if Pmin==P0 or accel_in==0.
- start_in while busy: ignored. Input changes during a move: ignored.
- steps_in==0: no move. done_out pulses after edge k; busy_out stays 0.
- Period counter:
  - cnt increments each cycle while busy.
  - When cnt==period-1: step_out=1 at the next edge, cnt returns to 0, steps_left decrements.
  - First step_out is high after edge k+P0, so P0=1 gives a step after k+1.
- Per-step update (same edge as step_out rises), with rem = steps_left-1:
  - rem==0: the move ends. busy_out=0 and state=IDLE at the edge after the last step_out; done_out is high for that one cycle.
  - else if rem<=ramp_cnt, or the abort flag is set: state=DECEL, period=min(period+accel_in, P0) saturating, ramp_cnt decrements (floor 0).
  - else if ACCEL: period=max(period-accel_in, Pmin). Compute the subtraction with a compare first; never wrap. ramp_cnt increments. State goes to CRUISE when the period reaches Pmin.
  - else (CRUISE): period unchanged.
- The new period governs the interval to the next step. This gives a symmetric profile, a triangle profile for short moves, and no cruise when Pmin is never reached.
- abort_in while busy: steps_left:=min(steps_left, ramp_cnt+1) and set the abort flag. The pending step still completes, then ramp_cnt decelerating steps follow and done_out pulses. Abort in IDLE is ignored; abort in DECEL is harmless.
- Simultaneous abort and terminal count: the step is emitted and counted first, then the clamp is applied to the post-decrement steps_left.
- period_out mirrors the loaded period and is held after done. dir_out is held after done until the next start.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0; start with rst_in high is ignored.
- P0=10, Pmin=4, accel=2, steps=8, start at edge k -> step intervals 10,8,6,4,4,6,8,10 (steps at k+10, +18, +24, +28, +32, +38, +46, +56); done_out at k+57; busy low after k+57.
- Same profile with steps=3 -> intervals 10,8,10; state never enters CRUISE; done after the 3rd step.
- Same profile with steps=20, abort_in pulsed 2 cycles after step 5 -> step 6 at interval 4, then intervals 6,8,10; 9 steps total; done_out pulses.
- steps=0 -> done_out pulses once, busy_out stays 0, no step_out. start_in re-pulsed while busy -> no effect on step count or period.
- Edge cases:
  - Pmin=12 with P0=10 -> constant interval 10.
  - P0=0 -> interval 1.
  - accel=7, period=8, Pmin=4 -> period 4 (no wrap).
  - rst_in asserted mid-cruise -> next cycle all outputs 0, no done.
